gb_int_ctrl: RTL and testbench
==============================

Name: gb_int_ctrl

Overview:
- Memory-mapped interrupt controller on the far side of the CPU bus.
- Owns the IF register (0xFF0F) and IE register (0xFFFF), and drives the reg_IF / reg_IE inputs of gb_cpu.
- Latches rising-edge interrupt requests from the peripherals: VBlank, STAT, Timer, Serial, Joypad.
- Responds to CPU bus reads and writes, and clears IF bits on CPU service acknowledge.

Parameters:
- NUM_IRQ, 5, number of interrupt lines (bits 0..NUM_IRQ-1 of IF); fixed at 5 for DMG.
- VEC_BASE, 16'h0040, handler address of bit 0.
- VEC_STRIDE, 8, address spacing between handler vectors.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- addr_i  input  16  CPU address bus (gb_cpu addr_o).
- data_i  input  8  CPU write data (gb_cpu data_o).
- wr_en_i  input  1  CPU write strobe (gb_cpu drive_data_bus).
- data_o  output  8  read data; valid when sel_o=1.
- sel_o  output  1  address hit on 0xFF0F or 0xFFFF; the bus mux uses it.
- irq_req_i  input  NUM_IRQ  level requests from peripherals.
- int_ack_i  input  NUM_IRQ  one-hot service acknowledge from the CPU.
- reg_IF  output  8  IF to the CPU: {3'b111, if_q}.
- reg_IE  output  8  IE to the CPU: full 8-bit ie_q.
- int_pending_o  output  1  |(if_q & ie_q[4:0]).
- int_vec_o  output  16  handler address of the highest-priority pending bit (lowest index wins); 16'h0000 when none pending.

Behaviour:
- Reset (async, immediate):
  - if_q=5'b0, ie_q=8'h00, edge-detect history=0.
  - Outputs: reg_IF=8'hE0, reg_IE=8'h00, int_pending_o=0, int_vec_o=0.
  - data_o and sel_o follow addr_i combinationally.
- Reads (combinational, zero latency):
  - sel_o=1 iff addr_i==0xFF0F or 0xFFFF.
  - data_o = reg_IF at 0xFF0F, reg_IE at 0xFFFF, 8'hFF otherwise.
- Writes (on posedge when wr_en_i=1):
  - At 0xFFFF: ie_q <= data_i (all 8 bits stored).
  - At 0xFF0F: if_q <= data_i[4:0]; bits 7:5 are discarded.
- Edge detect:
  - rise[i] = irq_req_i[i] & ~req_prev[i]; req_prev <= irq_req_i every cycle.
  - A request held high sets IF exactly once.
  - Latency: req high before edge N sets IF at edge N (visible in reg_IF after edge N).
- IF next-state, same-cycle precedence:
  - base = CPU write value if 0xFF0F written, else if_q.
  - then base & ~int_ack_i.
  - then | rise.
  - Order: edge set beats ack clear beats CPU write.
- A write to any other address is ignored.
- A write to 0xFF0F in the same cycle as an ack acts on the written value.
- int_vec_o = VEC_BASE + VEC_STRIDE*k, where k = lowest set bit of (if_q & ie_q[4:0]). Combinational from registers.
- A reset asserted mid-operation discards all pending and in-flight edges.
- After reset deassert, a line already high produces a rise on the first edge, because history resets to 0.

Optional Feature:
- Macro: GB_INT_IRQ_SYNC_EN.
- Defined: each irq_req_i bit passes through a 2-flop synchronizer (reset to 0) before edge detect. Latency becomes 3 edges.
- Undefined: irq_req_i feeds edge detect directly, with 1-edge latency. No extra flops.

Decomposition:
- Package gb_int_pkg:
  - IF_ADDR=16'hFF0F, IE_ADDR=16'hFFFF, IF_UNUSED=8'hE0.
  - Enum irq_idx_e: VBLANK=0, STAT=1, TIMER=2, SERIAL=3, JOYPAD=4.
  - VEC_BASE and VEC_STRIDE defaults.
- Sub-module gb_irq_edge:
  - One instance per line: optional synchronizer plus prev flop.
  - Outputs a 1-cycle rise pulse.
- Top level holds the registers, address decode, and priority encoder.

Test Plan:
- Reset: assert reset mid-cycle with if_q=5'h1F -> reg_IF=8'hE0 immediately, reg_IE=8'h00, int_pending_o=0, int_vec_o=0.
- Bus access: write 8'h05 to 0xFFFF, then 8'hFF to 0xFF0F -> read 0xFFFF=8'h05, read 0xFF0F=8'hFF, reg_IF=8'hFF. Read 0x1234 -> sel_o=0.
- Edge and one-shot: TIMER req high for 4 cycles -> IF=8'hE4 after the first edge. Write 8'hE0 to 0xFF0F while req is still high -> IF stays 8'hE0.
- Priority: IE=8'h1F, raise STAT and SERIAL -> int_vec_o=16'h0048, pending=1. Ack 5'b00010 -> int_vec_o=16'h0058. Ack 5'b01000 -> int_vec_o=0, pending=0.
- Collisions:
  - Write 8'h00 to 0xFF0F in the same cycle as a JOYPAD rise -> reg_IF=8'hF0.
  - VBLANK ack in the same cycle as a VBLANK rise -> bit 0 stays set.
- With GB_INT_IRQ_SYNC_EN: SERIAL req rises before edge N -> IF bit 3 set after edge N+2, not earlier.

Source files
------------

// File: rtl/gb_int_pkg.sv
// Shared constants for the DMG interrupt controller: register addresses,
// interrupt line indices and default handler vector layout.
package gb_int_pkg;

    localparam logic [15:0] IF_ADDR   = 16'hFF0F;
    localparam logic [15:0] IE_ADDR   = 16'hFFFF;
    localparam logic [7:0]  IF_UNUSED = 8'hE0;

    localparam logic [15:0] GB_VEC_BASE   = 16'h0040;
    localparam int          GB_VEC_STRIDE = 8;

    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } irq_idx_e;

endpackage

// File: rtl/gb_irq_edge.sv
// Rising-edge detector for one interrupt request line.
// With GB_INT_IRQ_SYNC_EN defined the line first passes a 2-flop synchronizer.
module gb_irq_edge (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    output logic rise_o
);

    logic req_s;
    logic prev_q;

`ifdef GB_INT_IRQ_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= req_i;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_i;
`endif

    // History clears on reset so a line already high fires on the first edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= req_s;
        end
    end

    assign rise_o = req_s & ~prev_q;

endmodule

// File: rtl/gb_int_ctrl.sv
// DMG interrupt controller: IF (0xFF0F) / IE (0xFFFF) registers, request edge
// latching, CPU acknowledge clearing and vector priority encoding.
// Optional request synchronizers are enabled with GB_INT_IRQ_SYNC_EN.
module gb_int_ctrl
    import gb_int_pkg::*;
#(
    parameter int          NUM_IRQ    = 5,
    parameter logic [15:0] VEC_BASE   = GB_VEC_BASE,
    parameter int          VEC_STRIDE = GB_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        addr_i,
    input  logic [7:0]         data_i,
    input  logic               wr_en_i,
    output logic [7:0]         data_o,
    output logic               sel_o,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [NUM_IRQ-1:0] int_ack_i,
    output logic [7:0]         reg_IF,
    output logic [7:0]         reg_IE,
    output logic               int_pending_o,
    output logic [15:0]        int_vec_o
);

    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_d;
    logic [7:0]         ie_q;
    logic [7:0]         ie_d;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend;
    logic               wr_if;
    logic               wr_ie;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_edge
        gb_irq_edge u_edge (
            .clk    (clk),
            .reset  (reset),
            .req_i  (irq_req_i[i]),
            .rise_o (rise[i])
        );
    end

    assign wr_if = wr_en_i && (addr_i == IF_ADDR);
    assign wr_ie = wr_en_i && (addr_i == IE_ADDR);

    // Precedence: peripheral edge beats CPU ack, which beats a CPU write.
    always_comb begin
        if_d = wr_if ? data_i[NUM_IRQ-1:0] : if_q;
        if_d = (if_d & ~int_ack_i) | rise;
        ie_d = wr_ie ? data_i : ie_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_q <= '0;
            ie_q <= 8'h00;
        end else begin
            if_q <= if_d;
            ie_q <= ie_d;
        end
    end

    assign reg_IF = IF_UNUSED | {{(8-NUM_IRQ){1'b0}}, if_q};
    assign reg_IE = ie_q;

    assign sel_o = (addr_i == IF_ADDR) || (addr_i == IE_ADDR);

    always_comb begin
        data_o = 8'hFF;
        if (addr_i == IF_ADDR) begin
            data_o = reg_IF;
        end else if (addr_i == IE_ADDR) begin
            data_o = reg_IE;
        end
    end

    assign pend          = if_q & ie_q[NUM_IRQ-1:0];
    assign int_pending_o = |pend;

    // Scan from the top so the lowest pending index is the one left standing.
    always_comb begin
        int_vec_o = 16'h0000;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                int_vec_o = VEC_BASE + 16'(VEC_STRIDE * i);
            end
        end
    end

endmodule

// File: tb/tb_gb_int_ctrl.sv
// Directed self-checking bench for gb_int_ctrl (default and synchronized builds).
module tb_gb_int_ctrl;
    import gb_int_pkg::*;

`ifdef GB_INT_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr_i = 16'h0000;
    logic [7:0]  data_i = 8'h00;
    logic        wr_en_i = 1'b0;
    logic [7:0]  data_o;
    logic        sel_o;
    logic [4:0]  irq_req_i = 5'b0;
    logic [4:0]  int_ack_i = 5'b0;
    logic [7:0]  reg_IF;
    logic [7:0]  reg_IE;
    logic        int_pending_o;
    logic [15:0] int_vec_o;

    int checks = 0;
    int errors = 0;

    gb_int_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .wr_en_i       (wr_en_i),
        .data_o        (data_o),
        .sel_o         (sel_o),
        .irq_req_i     (irq_req_i),
        .int_ack_i     (int_ack_i),
        .reg_IF        (reg_IF),
        .reg_IE        (reg_IE),
        .int_pending_o (int_pending_o),
        .int_vec_o     (int_vec_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr_i  = a;
        data_i  = d;
        wr_en_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        addr_i  = 16'h0000;
    endtask

    task automatic flush();
        irq_req_i = 5'b0;
        int_ack_i = 5'b0;
        repeat (LAT + 1) tick();
        bus_write(IF_ADDR, 8'h00);
    endtask

    task automatic test_reset();
        addr_i = IF_ADDR;
        #3;
        checks++; if (reg_IF !== 8'hE0) begin errors++; $display("FAIL reset_if: got %h exp e0", reg_IF); end
        checks++; if (reg_IE !== 8'h00) begin errors++; $display("FAIL reset_ie: got %h exp 00", reg_IE); end
        checks++; if (int_pending_o !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b exp 0", int_pending_o); end
        checks++; if (int_vec_o !== 16'h0000) begin errors++; $display("FAIL reset_vec: got %h exp 0000", int_vec_o); end
        checks++; if (data_o !== 8'hE0 || sel_o !== 1'b1) begin errors++; $display("FAIL reset_read: got %h/%b exp e0/1", data_o, sel_o); end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_bus();
        bus_write(IE_ADDR, 8'h05);
        bus_write(IF_ADDR, 8'hFF);
        addr_i = IE_ADDR; #1;
        checks++; if (data_o !== 8'h05 || sel_o !== 1'b1) begin errors++; $display("FAIL rd_ie: got %h/%b exp 05/1", data_o, sel_o); end
        addr_i = IF_ADDR; #1;
        checks++; if (data_o !== 8'hFF || sel_o !== 1'b1) begin errors++; $display("FAIL rd_if: got %h/%b exp ff/1", data_o, sel_o); end
        checks++; if (reg_IF !== 8'hFF) begin errors++; $display("FAIL reg_if_ff: got %h exp ff", reg_IF); end
        addr_i = 16'h1234; #1;
        checks++; if (data_o !== 8'hFF || sel_o !== 1'b0) begin errors++; $display("FAIL rd_other: got %h/%b exp ff/0", data_o, sel_o); end
        bus_write(16'h1234, 8'h00);
        bus_write(16'hFF0E, 8'h00);
        checks++; if (reg_IF !== 8'hFF || reg_IE !== 8'h05) begin errors++; $display("FAIL wr_other: got %h/%h exp ff/05", reg_IF, reg_IE); end
        bus_write(IF_ADDR, 8'h00);
    endtask

    task automatic test_edge();
        irq_req_i[TIMER] = 1'b1;
        repeat (LAT) tick();
        checks++; if (reg_IF !== 8'hE4) begin errors++; $display("FAIL edge_set: got %h exp e4", reg_IF); end
        repeat (3) tick();
        bus_write(IF_ADDR, 8'hE0);
        checks++; if (reg_IF !== 8'hE0) begin errors++; $display("FAIL edge_clr: got %h exp e0", reg_IF); end
        repeat (3) tick();
        checks++; if (reg_IF !== 8'hE0) begin errors++; $display("FAIL one_shot: got %h exp e0", reg_IF); end
        flush();
    endtask

    task automatic test_priority();
        bus_write(IE_ADDR, 8'h1F);
        irq_req_i[STAT]   = 1'b1;
        irq_req_i[SERIAL] = 1'b1;
        repeat (LAT) tick();
        checks++; if (int_vec_o !== 16'h0048 || int_pending_o !== 1'b1) begin errors++; $display("FAIL prio_stat: got %h/%b exp 0048/1", int_vec_o, int_pending_o); end
        int_ack_i = 5'b00010;
        tick();
        int_ack_i = 5'b00000;
        checks++; if (int_vec_o !== 16'h0058 || int_pending_o !== 1'b1) begin errors++; $display("FAIL prio_serial: got %h/%b exp 0058/1", int_vec_o, int_pending_o); end
        int_ack_i = 5'b01000;
        tick();
        int_ack_i = 5'b00000;
        checks++; if (int_vec_o !== 16'h0000 || int_pending_o !== 1'b0) begin errors++; $display("FAIL prio_none: got %h/%b exp 0000/0", int_vec_o, int_pending_o); end
        bus_write(IE_ADDR, 8'h04);
        bus_write(IF_ADDR, 8'h06);
        checks++; if (int_vec_o !== 16'h0050 || int_pending_o !== 1'b1) begin errors++; $display("FAIL prio_masked: got %h/%b exp 0050/1", int_vec_o, int_pending_o); end
        flush();
    endtask

    task automatic test_collision();
        bus_write(IF_ADDR, 8'h0F);
        irq_req_i[JOYPAD] = 1'b1;
        repeat (LAT - 1) tick();
        bus_write(IF_ADDR, 8'h00);
        checks++; if (reg_IF !== 8'hF0) begin errors++; $display("FAIL wr_vs_rise: got %h exp f0", reg_IF); end
        flush();
        bus_write(IF_ADDR, 8'h01);
        irq_req_i[VBLANK] = 1'b1;
        repeat (LAT - 1) tick();
        int_ack_i = 5'b00001;
        tick();
        int_ack_i = 5'b00000;
        checks++; if (reg_IF !== 8'hE1) begin errors++; $display("FAIL ack_vs_rise: got %h exp e1", reg_IF); end
        flush();
        int_ack_i = 5'b00100;
        bus_write(IF_ADDR, 8'h1F);
        int_ack_i = 5'b00000;
        checks++; if (reg_IF !== 8'hFB) begin errors++; $display("FAIL ack_vs_wr: got %h exp fb", reg_IF); end
        flush();
    endtask

    task automatic test_reset_mid();
        bus_write(IF_ADDR, 8'h1F);
        bus_write(IE_ADDR, 8'h1F);
        irq_req_i = 5'b00001;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (reg_IF !== 8'hE0 || reg_IE !== 8'h00) begin errors++; $display("FAIL mid_reset_regs: got %h/%h exp e0/00", reg_IF, reg_IE); end
        checks++; if (int_pending_o !== 1'b0 || int_vec_o !== 16'h0000) begin errors++; $display("FAIL mid_reset_out: got %b/%h exp 0/0000", int_pending_o, int_vec_o); end
        repeat (2) tick();
        reset = 1'b0;
        repeat (LAT) tick();
        checks++; if (reg_IF !== 8'hE1) begin errors++; $display("FAIL post_reset_rise: got %h exp e1", reg_IF); end
        flush();
    endtask

`ifdef GB_INT_IRQ_SYNC_EN
    task automatic test_sync();
        irq_req_i[SERIAL] = 1'b1;
        tick();
        checks++; if (reg_IF !== 8'hE0) begin errors++; $display("FAIL sync_n: got %h exp e0", reg_IF); end
        tick();
        checks++; if (reg_IF !== 8'hE0) begin errors++; $display("FAIL sync_n1: got %h exp e0", reg_IF); end
        tick();
        checks++; if (reg_IF !== 8'hE8) begin errors++; $display("FAIL sync_n2: got %h exp e8", reg_IF); end
        flush();
    endtask
`endif

    initial begin
        test_reset();
        test_bus();
        test_edge();
        test_priority();
        test_collision();
        test_reset_mid();
`ifdef GB_INT_IRQ_SYNC_EN
        test_sync();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
